// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register bit map
// of the hold/flush vectors and the squash FSM encoding.
package pipe_ctrl_pkg;

  localparam int HOLD_PC  = 0;
  localparam int HOLD_IF  = 1;
  localparam int HOLD_ID  = 2;
  localparam int HOLD_EX  = 3;
  localparam int HOLD_MEM = 4;

  localparam int NUM_REGS = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic                mem_stall_i;
  logic                ex_busy_i;
  logic                load_use_i;
  logic                jump_req_i;
  logic [31:0]         jump_addr_i;
  logic [NUM_REGS-1:0] hold_en_o;
  logic [NUM_REGS-1:0] flush_o;
  logic                jump_en_o;
  logic [31:0]         jump_addr_o;
  logic [CNT_W-1:0]    stall_cnt_o;

  modport master (
    output mem_stall_i, ex_busy_i, load_use_i, jump_req_i, jump_addr_i,
    input  hold_en_o, flush_o, jump_en_o, jump_addr_o, stall_cnt_o
  );

  modport slave (
    input  mem_stall_i, ex_busy_i, load_use_i, jump_req_i, jump_addr_i,
    output hold_en_o, flush_o, jump_en_o, jump_addr_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_dff.sv
// Enabled D flip-flop with asynchronous active-high clear to zero.
module pipe_ctrl_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Merges MEM/EX/ID stall and redirect requests into hold/flush vectors and
// squashes if_id for FLUSH_CYC unstalled cycles after a taken jump.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC);

  state_e              state;
  logic [2:0]          cnt;
  logic [NUM_REGS-1:0] hold;
  logic [NUM_REGS-1:0] flush;
  logic                jump_en;
  logic                advance;
  logic [CNT_W-1:0]    stall_cnt;

  // Strict priority: MEM stall > EX busy > jump > load-use > squash window.
  always_comb begin
    hold    = '0;
    flush   = '0;
    jump_en = 1'b0;
    advance = 1'b0;
    if (bus.mem_stall_i) begin
      hold = '1;
    end else if (bus.ex_busy_i) begin
      hold[HOLD_PC] = 1'b1;
      hold[HOLD_IF] = 1'b1;
      hold[HOLD_ID] = 1'b1;
      flush[HOLD_EX] = 1'b1;
    end else begin
      advance = 1'b1;
      if (bus.jump_req_i) begin
        jump_en = 1'b1;
        flush[HOLD_IF] = 1'b1;
        flush[HOLD_ID] = 1'b1;
      end else begin
        if (bus.load_use_i) begin
          hold[HOLD_PC]  = 1'b1;
          hold[HOLD_IF]  = 1'b1;
          flush[HOLD_ID] = 1'b1;
        end
        if (state == FLUSH)
          flush[HOLD_IF] = 1'b1;
      end
    end
  end

  // The squash window only advances on cycles where EX and MEM are not held,
  // so stalls stretch it rather than eat into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (advance) begin
      if (jump_en) begin
        if (FLUSH_CYC > 0) begin
          state <= FLUSH;
          cnt   <= FLUSH_LD;
        end
      end else if (state == FLUSH) begin
        if (cnt <= 3'd1) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  pipe_ctrl_dff #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hold[HOLD_PC]),
    .d   (stall_cnt + CNT_W'(1)),
    .q   (stall_cnt)
  );

  assign bus.hold_en_o   = hold;
  assign bus.flush_o     = flush;
  assign bus.jump_en_o   = jump_en;
  assign bus.jump_addr_o = bus.jump_addr_i;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Two controllers (FLUSH_CYC=1/CNT_W=32 and FLUSH_CYC=3/CNT_W=4) driven in
// parallel and compared each cycle against a request-level reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_stall, ex_busy, load_use, jump_req;
  logic [31:0] jaddr;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) b0 ();
  pipe_ctrl_if #(.CNT_W(4))  b1 ();

  pipe_ctrl #(.FLUSH_CYC(1), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  pipe_ctrl #(.FLUSH_CYC(3), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b0.mem_stall_i = mem_stall;
  assign b0.ex_busy_i   = ex_busy;
  assign b0.load_use_i  = load_use;
  assign b0.jump_req_i  = jump_req;
  assign b0.jump_addr_i = jaddr;
  assign b1.mem_stall_i = mem_stall;
  assign b1.ex_busy_i   = ex_busy;
  assign b1.load_use_i  = load_use;
  assign b1.jump_req_i  = jump_req;
  assign b1.jump_addr_i = jaddr;

  logic [4:0]  hold_d  [2];
  logic [4:0]  flush_d [2];
  logic        jen_d   [2];
  logic [31:0] jaddr_d [2];
  logic [31:0] stall_d [2];

  assign hold_d[0]  = b0.hold_en_o;
  assign hold_d[1]  = b1.hold_en_o;
  assign flush_d[0] = b0.flush_o;
  assign flush_d[1] = b1.flush_o;
  assign jen_d[0]   = b0.jump_en_o;
  assign jen_d[1]   = b1.jump_en_o;
  assign jaddr_d[0] = b0.jump_addr_o;
  assign jaddr_d[1] = b1.jump_addr_o;
  assign stall_d[0] = b0.stall_cnt_o;
  assign stall_d[1] = {28'b0, b1.stall_cnt_o};

  int          vectors = 0;
  int          miscompares = 0;
  // Reference state: remaining squash cycles and stall-cycle tally.
  int          sq [2];
  logic [31:0] st [2];
  int          fc [2] = '{1, 3};
  logic [31:0] st_mask [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] model_out(input int k);
    logic [4:0] h, f;
    logic       j;
    h = '0; f = '0; j = 1'b0;
    if (mem_stall) h = 5'b11111;
    else if (ex_busy) begin h = 5'b00111; f = 5'b01000; end
    else if (jump_req) begin j = 1'b1; f = 5'b00110; end
    else begin
      if (load_use) begin h = 5'b00011; f = 5'b00100; end
      if (sq[k] > 0) f = f | 5'b00010;
    end
    return {j, f, h};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin sq[k] = 0; st[k] = '0; end
  endtask

  task automatic check_all();
    logic [10:0] o;
    if (rst) model_clear();
    for (int k = 0; k < 2; k++) begin
      o = model_out(k);
      chk($sformatf("dut%0d hold", k),  {27'b0, hold_d[k]},  {27'b0, o[4:0]});
      chk($sformatf("dut%0d flush", k), {27'b0, flush_d[k]}, {27'b0, o[9:5]});
      chk($sformatf("dut%0d jump_en", k), {31'b0, jen_d[k]}, {31'b0, o[10]});
      chk($sformatf("dut%0d jump_addr", k), jaddr_d[k], jaddr);
      chk($sformatf("dut%0d stall_cnt", k), stall_d[k], st[k] & st_mask[k]);
    end
  endtask

  task automatic model_clock();
    logic [10:0] o;
    for (int k = 0; k < 2; k++) begin
      o = model_out(k);
      if (rst) begin
        sq[k] = 0; st[k] = '0;
      end else begin
        if (o[0]) st[k] = st[k] + 32'd1;
        if (!mem_stall && !ex_busy) begin
          if (jump_req) sq[k] = fc[k];
          else if (sq[k] > 0) sq[k] = sq[k] - 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle(input int n);
    mem_stall = 0; ex_busy = 0; load_use = 0; jump_req = 0;
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1;
    mem_stall = 0; ex_busy = 0; load_use = 0; jump_req = 0; jaddr = '0;
    model_clear();

    // Reset then idle
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("idle hold", {27'b0, b0.hold_en_o}, 32'h0);
    chk("idle stall_cnt", b0.stall_cnt_o, 32'h0);

    // Load-use pulse
    load_use = 1'b1; #1;
    chk("lu hold", {27'b0, b0.hold_en_o}, 32'h03);
    chk("lu flush", {27'b0, b0.flush_o}, 32'h04);
    cycle();
    load_use = 1'b0; #1;
    chk("lu stall_cnt", b0.stall_cnt_o, 32'd1);
    idle(2);

    // Jump with FLUSH_CYC = 1
    jump_req = 1'b1; jaddr = 32'h0000_0100; #1;
    chk("jmp en", {31'b0, b0.jump_en_o}, 32'h1);
    chk("jmp addr", b0.jump_addr_o, 32'h100);
    chk("jmp flush", {27'b0, b0.flush_o}, 32'h06);
    cycle();
    jump_req = 1'b0; #1;
    chk("jmp+1 flush", {27'b0, b0.flush_o}, 32'h02);
    cycle();
    chk("jmp+2 flush", {27'b0, b0.flush_o}, 32'h00);
    idle(4);

    // MEM stall masking a pending jump
    mem_stall = 1'b1; jump_req = 1'b1; jaddr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ms hold", {27'b0, b0.hold_en_o}, 32'h1F);
      chk("ms jump_en", {31'b0, b0.jump_en_o}, 32'h0);
      cycle();
    end
    mem_stall = 1'b0; #1;
    chk("ms release jump_en", {31'b0, b0.jump_en_o}, 32'h1);
    cycle();
    jump_req = 1'b0; idle(4);
    chk("ms stall_cnt", b0.stall_cnt_o, 32'd5);

    // Mul/div busy hiding a load-use
    ex_busy = 1'b1; load_use = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("busy hold", {27'b0, b0.hold_en_o}, 32'h07);
      chk("busy flush", {27'b0, b0.flush_o}, 32'h08);
      cycle();
    end
    ex_busy = 1'b0; #1;
    chk("busy->lu hold", {27'b0, b0.hold_en_o}, 32'h03);
    chk("busy->lu flush", {27'b0, b0.flush_o}, 32'h04);
    cycle();
    idle(2);
    chk("busy stall_cnt", b0.stall_cnt_o, 32'd12);

    // Asynchronous reset in the middle of a FLUSH_CYC = 3 window
    idle(4);
    jump_req = 1'b1; jaddr = 32'h0000_0300;
    cycle();
    jump_req = 1'b0; #1;
    chk("pre-rst flush", {27'b0, b1.flush_o}, 32'h02);
    rst = 1'b1; #1;
    chk("rst flush", {27'b0, b1.flush_o}, 32'h00);
    chk("rst stall_cnt", {28'b0, b1.stall_cnt_o}, 32'h0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("post-rst flush", {27'b0, b1.flush_o}, 32'h00);
    idle(2);

    // Randomized traffic, occasional resets
    for (int i = 0; i < 1500; i++) begin
      mem_stall = ($urandom_range(0, 99) < 15);
      ex_busy   = ($urandom_range(0, 99) < 15);
      load_use  = ($urandom_range(0, 99) < 20);
      jump_req  = ($urandom_range(0, 99) < 20);
      jaddr     = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage Deilt_RISCV core. It merges stall and redirect requests from ID, EX and MEM into per-register hold and flush vectors. Those vectors drive the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers. A small FSM squashes stale fetch data for a programmable number of cycles after a taken jump, and a counter tracks stall cycles for performance monitoring.

## Interface
- FLUSH_CYC, default 1: extra cycles if_id is squashed after a jump redirect. Range 0–7.
- CNT_W, default 32: width of the stall-cycle counter.
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- mem_stall_i  in  1  MEM stage waiting on the data bus.
- ex_busy_i  in  1  multi-cycle mul/div in EX has not finished.
- load_use_i  in  1  ID has detected a load-use hazard against EX.
- jump_req_i  in  1  EX has resolved a taken branch or jump.
- jump_addr_i  in  32  target address of that branch or jump.
- hold_en_o  out  5  hold vector: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb. A 1 freezes that register.
- flush_o  out  5  flush vector, same bit map. A 1 loads NOP/zero into that register at the next edge.
- jump_en_o  out  1  redirects the PC to jump_addr_o this cycle.
- jump_addr_o  out  32  redirect target, equal to jump_addr_i.
- stall_cnt_o  out  CNT_W  count of cycles in which hold_en_o[0] was 1.

## Operation
- Outputs are combinational (Mealy) from the inputs and registered state. Requests are resolved in strict priority order, as below.
- **mem_stall_i = 1**
  - hold_en_o = 5'b11111, flush_o = 0, jump_en_o = 0.
  - The FLUSH counter is frozen.
- **Otherwise, ex_busy_i = 1**
  - hold_en_o = 5'b00111, flush_o = 5'b01000 (bubble into ex_mem), jump_en_o = 0.
- **Otherwise, jump_req_i = 1**
  - jump_en_o = 1, hold_en_o = 0, flush_o = 5'b00110 (squash if_id and id_ex).
  - If FLUSH_CYC > 0: load cnt = FLUSH_CYC and go to FLUSH.
- **Otherwise, load_use_i = 1**
  - hold_en_o = 5'b00011, flush_o = 5'b00100 (bubble into id_ex).
- **Otherwise**
  - In RUN: hold_en_o = 0, flush_o = 0.
  - In FLUSH: flush_o[1] = 1 and cnt decrements. Go to RUN when cnt reaches 1 at a clock edge.
- **FSM states**
  - RUN → FLUSH on an accepted jump (with FLUSH_CYC > 0).
  - FLUSH → RUN after cnt expires.
  - FLUSH → FLUSH on another accepted jump; cnt reloads to FLUSH_CYC.
- **Stalled requests are not lost**
  - EX and MEM inputs stay stable while their stages are held.
  - A jump_req_i that is masked by mem_stall_i or ex_busy_i is therefore taken on the first unmasked cycle. No latching is required.
- **Load-use in FLUSH**
  - load_use_i during FLUSH still applies its hold and flush.
  - flush_o[1] stays 1 and is ORed with the load-use flush.
  - cnt still decrements.
- **stall_cnt_o**
  - Increments on every cycle with hold_en_o[0] = 1.
  - Wraps modulo 2^CNT_W and never saturates.

## Timing
- Reset values:
  - state = RUN, cnt = 0, stall_cnt_o = 0.
  - With all inputs 0: hold_en_o = 0, flush_o = 0, jump_en_o = 0, jump_addr_o = jump_addr_i.
- Response latency:
  - hold, flush and jump outputs respond in the same cycle as the request (0 cycles).
  - Flush and hold take effect in the pipeline registers at the next rising edge.
- Post-jump squash:
  - if_id is squashed for the jump cycle plus FLUSH_CYC following unstalled cycles.
  - Stalled cycles extend this window.
- Asynchronous rst mid-FLUSH forces RUN immediately and clears cnt and stall_cnt_o.
- Simultaneous requests are resolved only by the priority order above. Lower-priority requests see no partial effect.

## Structure
- Hold and flush bit indices belong in defines.v: HOLD_PC, HOLD_IF, HOLD_ID, HOLD_EX, HOLD_MEM.
- The FSM state encodings RUN and FLUSH also belong in defines.v.
- State, cnt and stall_cnt_o are built from the existing gnrl_dff-family cells. No other sub-module is needed.

## Test plan
- **Reset then idle:** hold rst for 3 cycles, release with inputs low → all outputs 0 and stall_cnt_o = 0.
- **Load-use:** pulse load_use_i for 1 cycle → that cycle shows hold 5'b00011 and flush 5'b00100; stall_cnt_o = 1 afterwards.
- **Jump, FLUSH_CYC = 1:** jump_req_i = 1 with addr 0x0000_0100 for 1 cycle →
  - jump cycle: jump_en_o = 1, jump_addr_o = 0x100, flush 5'b00110.
  - next cycle: flush 5'b00010.
  - then back to 0.
- **Mem stall masking a jump:** mem_stall_i = 1 for 4 cycles with jump_req_i held at 1 →
  - hold = 5'b11111 and jump_en_o = 0 for 4 cycles.
  - jump_en_o = 1 on the 5th cycle.
  - stall_cnt_o = 4.
- **Mul/div with load-use:** ex_busy_i = 1 for 6 cycles together with load_use_i = 1 → hold 5'b00111 and flush 5'b01000 throughout; the load-use outputs appear only after busy drops.
- **Reset during FLUSH:**
  - FLUSH_CYC = 3; jump, then assert rst 1 cycle later → flush_o = 0 as soon as rst is high.
  - After release, state is RUN.
